multi_cycle_adder: RTL and testbench
====================================

Name: multi_cycle_adder

Overview:
- Parametrised multi-cycle adder/subtractor; successor to the single-bit full-adder cell.
- Processes DIGIT bits per clock over WIDTH-bit operands, carrying between digits in a register.
- Start/done handshake for use by the ALU and the multi-cycle datapath where area matters more than latency.
- Produces sum, carry-out, signed overflow and zero flags.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of DIGIT.
DIGIT, 4, bits added per cycle; 1 <= DIGIT <= WIDTH.

Ports:
clk_i  input  1  clock; all state updates on rising edge.
rst_i  input  1  asynchronous active-low reset.
start_i  input  1  request; sampled only in IDLE or DONE.
sub_i  input  1  0 = add, 1 = subtract (src1 - src2); latched with start.
cin_i  input  1  carry-in for add; ignored when sub_i = 1.
src1_i  input  WIDTH  operand A; latched with start.
src2_i  input  WIDTH  operand B; latched with start.
busy_o  output  1  high while in RUN.
done_o  output  1  one-cycle pulse; results valid.
sum_o  output  WIDTH  result.
cout_o  output  1  carry out of the MSB. For subtract: 1 = no borrow.
overflow_o  output  1  signed overflow.
zero_o  output  1  sum_o == 0.

Behaviour:
- Reset (rst_i = 0, asynchronous) sets:
  - state to IDLE and the digit counter to 0;
  - all internal operand and carry registers to 0;
  - busy_o, done_o, sum_o, cout_o, overflow_o and zero_o to 0.
- Reset mid-RUN abandons the operation; no done_o is produced.
- N = WIDTH/DIGIT.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - With start_i = 1 at an edge, latch src1_i and the effective B.
  - Effective B is src2_i if sub_i = 0, ~src2_i if sub_i = 1.
  - Latch carry = cin_i for add, 1 for subtract.
  - Clear counter; go to RUN.
- RUN:
  - Each edge adds digit k (bits k*DIGIT+DIGIT-1 : k*DIGIT) of A, B and the carry register.
  - Writes that digit into the partial-sum register, updates carry, increments the counter.
  - After the edge processing digit N-1, go to DONE.
  - The carry into the MSB (bit WIDTH-1) is captured for the overflow computation.
  - start_i is ignored in RUN; operands and sub_i may change freely without effect.
- DONE:
  - Lasts exactly one cycle, with done_o = 1.
  - On entry, sum_o, cout_o, overflow_o and zero_o update from the final partial sum and carry.
  - If start_i = 1 in DONE, the next operation is latched (back-to-back, go to RUN). Otherwise go to IDLE.
- Latency: start sampled at edge T gives done_o high in the cycle following edge T+N (N+1 edges total). Throughput is one operation per N+1 cycles.
- busy_o is high in RUN only.
- Outputs sum_o and the flags hold their values from the most recent DONE until the next DONE or reset; they do not change during RUN.
- Flag definitions:
  - cout_o = carry out of bit WIDTH-1.
  - overflow_o = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - zero_o = (sum_o == 0).
- Arithmetic is modulo 2^WIDTH. DIGIT = WIDTH degenerates to a single RUN cycle (N = 1).

Optional Feature:
- Macro: MULTI_CYCLE_ADDER_ABORT_EN.
- When defined:
  - Adds input port abort_i (1 bit), placed after start_i.
  - abort_i = 1 sampled in RUN returns the state to IDLE at that edge, clears the counter and carry, and produces no done_o.
  - sum_o and the flags keep their previous values.
  - abort_i is ignored in IDLE and DONE; in those states start_i behaves normally.
- When undefined: no abort_i port; every RUN completes.

Test Plan:
1. WIDTH=32, DIGIT=4: src1=0xFFFFFFFF, src2=0x00000001, add, cin=0 -> done_o exactly 9 edges after start sampled; sum_o=0x00000000, cout_o=1, overflow_o=0, zero_o=1; busy_o high for 8 cycles.
2. Add 0x7FFFFFFF + 0x00000001, cin=0 -> sum_o=0x80000000, cout_o=0, overflow_o=1, zero_o=0. Add 0x00000003 + 0x00000004, cin=1 -> sum_o=0x00000008.
3. Subtract 5 - 7 -> sum_o=0xFFFFFFFE, cout_o=0, overflow_o=0. Subtract 0x80000000 - 1 -> sum_o=0x7FFFFFFF, cout_o=1, overflow_o=1.
4. Handshake:
   - Pulse start_i again and change src1_i during RUN -> no effect; result matches the originally latched operands.
   - Hold start_i high in the DONE cycle with new operands -> second operation starts immediately; second done_o 9 edges later.
5. Reset:
   - Assert rst_i low asynchronously mid-RUN (after 3 digits) -> all outputs 0 immediately, no done_o follows.
   - After release, a new add 1 + 1 -> sum_o=2.
6. With MULTI_CYCLE_ADDER_ABORT_EN:
   - Abort in the 4th RUN cycle -> IDLE, no done_o, sum_o keeps the prior result.
   - A following start completes normally.
   - Repeat with DIGIT=1 and DIGIT=32 for latency 33 and 2 edges respectively.

Source files
------------

// File: rtl/multi_cycle_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, start/done handshake, sum and NZCV-style flags.
// Optional abort input enabled by defining MULTI_CYCLE_ADDER_ABORT_EN.
module multi_cycle_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
`ifdef MULTI_CYCLE_ADDER_ABORT_EN
  input  logic             abort_i,
`endif
  input  logic             sub_i,
  input  logic             cin_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             overflow_o,
  output logic             zero_o
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [WIDTH-1:0]   r_psum;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;
  logic               r_zero;

  logic               w_abort;
  logic               w_last;
  logic [DIGIT:0]     w_dsum;
  logic [WIDTH-1:0]   w_psum_next;
  logic               w_c_msb;
  logic               w_c_out;

`ifdef MULTI_CYCLE_ADDER_ABORT_EN
  assign w_abort = abort_i;
`else
  assign w_abort = 1'b0;
`endif

  // Operands shift right each RUN cycle, so the active digit is always the low one.
  assign w_last      = (r_cnt == LAST_CNT);
  assign w_dsum      = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
  assign w_psum_next = (r_psum >> DIGIT) | (WIDTH'(w_dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
  assign w_c_out     = w_dsum[DIGIT];
  // Carry into the top bit recovered from that bit's inputs and its sum bit.
  assign w_c_msb     = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_dsum[DIGIT-1];

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i) w_state_next = S_RUN;
        else         w_state_next = S_IDLE;
      end
      S_RUN: begin
        if (w_abort)     w_state_next = S_IDLE;
        else if (w_last) w_state_next = S_DONE;
        else             w_state_next = S_RUN;
      end
      S_DONE: begin
        if (start_i) w_state_next = S_RUN;
        else         w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Handshake outputs registered from the next state
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_next == S_RUN);
      r_done <= (w_state_next == S_DONE);
    end
  end

  // Operand latch, digit-serial datapath and result/flag capture
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt   <= {CNT_W{1'b0}};
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_carry <= 1'b0;
      r_psum  <= {WIDTH{1'b0}};
      r_sum   <= {WIDTH{1'b0}};
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            r_a     <= src1_i;
            r_b     <= sub_i ? ~src2_i : src2_i;
            r_carry <= sub_i ? 1'b1 : cin_i;
            r_cnt   <= {CNT_W{1'b0}};
          end
        end
        S_RUN: begin
          if (w_abort) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_carry <= 1'b0;
          end else begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_psum  <= w_psum_next;
            r_carry <= w_c_out;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_sum  <= w_psum_next;
              r_cout <= w_c_out;
              r_ovf  <= w_c_msb ^ w_c_out;
              r_zero <= (w_psum_next == {WIDTH{1'b0}});
            end
          end
        end
        default: begin
          r_cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign sum_o      = r_sum;
  assign cout_o     = r_cout;
  assign overflow_o = r_ovf;
  assign zero_o     = r_zero;

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Scoreboard bench for multi_cycle_adder: main instance DIGIT=4, plus DIGIT=1 and DIGIT=32 instances for latency.
// Abort scenarios are compiled in when MULTI_CYCLE_ADDER_ABORT_EN is defined.
module tb_multi_cycle_adder;

  localparam int W = 32;
  localparam int D = 4;
  localparam int N = W / D;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic         sub;
  logic         cin;
  logic [W-1:0] src1;
  logic [W-1:0] src2;

  logic         busy_m, done_m, cout_m, ovf_m, zero_m;
  logic [W-1:0] sum_m;
  logic         busy_1, done_1, cout_1, ovf_1, zero_1;
  logic [W-1:0] sum_1;
  logic         busy_32, done_32, cout_32, ovf_32, zero_32;
  logic [W-1:0] sum_32;

  exp_t         sb_q[$];
  exp_t         mon_e;
  logic [W-1:0] last_sum;
  int           n_checks = 0;
  int           n_errors = 0;

  always #5 clk = ~clk;

  multi_cycle_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start),
`ifdef MULTI_CYCLE_ADDER_ABORT_EN
    .abort_i(abort),
`endif
    .sub_i(sub), .cin_i(cin), .src1_i(src1), .src2_i(src2),
    .busy_o(busy_m), .done_o(done_m), .sum_o(sum_m), .cout_o(cout_m),
    .overflow_o(ovf_m), .zero_o(zero_m)
  );

  multi_cycle_adder #(.WIDTH(W), .DIGIT(1)) u_dut_d1 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start),
`ifdef MULTI_CYCLE_ADDER_ABORT_EN
    .abort_i(abort),
`endif
    .sub_i(sub), .cin_i(cin), .src1_i(src1), .src2_i(src2),
    .busy_o(busy_1), .done_o(done_1), .sum_o(sum_1), .cout_o(cout_1),
    .overflow_o(ovf_1), .zero_o(zero_1)
  );

  multi_cycle_adder #(.WIDTH(W), .DIGIT(W)) u_dut_d32 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start),
`ifdef MULTI_CYCLE_ADDER_ABORT_EN
    .abort_i(abort),
`endif
    .sub_i(sub), .cin_i(cin), .src1_i(src1), .src2_i(src2),
    .busy_o(busy_32), .done_o(done_32), .sum_o(sum_32), .cout_o(cout_32),
    .overflow_o(ovf_32), .zero_o(zero_32)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: add as wide sum, subtract as wide difference with borrow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic c);
    logic [W:0] full;
    exp_t       e;
    if (s) begin
      full   = {1'b0, a} - {1'b0, b};
      e.sum  = full[W-1:0];
      e.cout = ~full[W];
      e.ovf  = (a[W-1] != b[W-1]) && (e.sum[W-1] != a[W-1]);
    end else begin
      full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      e.sum  = full[W-1:0];
      e.cout = full[W];
      e.ovf  = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
    end
    e.zero = (e.sum == {W{1'b0}});
    return e;
  endfunction

  // Compare every done pulse of the main instance against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done_m === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("spurious_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("sum",      sum_m,  mon_e.sum);
        check_val("cout",     cout_m, mon_e.cout);
        check_val("overflow", ovf_m,  mon_e.ovf);
        check_val("zero",     zero_m, mon_e.zero);
        check_val("busy_in_done", busy_m, 64'd0);
        last_sum = mon_e.sum;
      end
    end
  end

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic c, input bit push);
    src1  = a;
    src2  = b;
    sub   = s;
    cin   = c;
    start = 1'b1;
    if (push) sb_q.push_back(model(a, b, s, c));
  endtask

  // Called right after launch; returns at the negedge of the done cycle.
  task automatic wait_done(input string tag, input bit disturb);
    int edges;
    int nbusy;
    bit seen;
    edges = 0;
    nbusy = 0;
    seen  = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_m) begin
        seen = 1'b1;
        break;
      end
      if (busy_m) nbusy++;
      if (disturb && edges == 2) begin
        start = 1'b1;
        src1  = ~src1;
        src2  = ~src2;
        sub   = ~sub;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      edges++;
    end
    check_val({tag, "_done_seen"}, seen, 64'd1);
    check_val({tag, "_latency"}, edges, N);
    check_val({tag, "_busy_cycles"}, nbusy, N);
  endtask

  logic [W-1:0] va [8];
  logic [W-1:0] vb [8];
  logic         vs [8];
  logic         vc [8];

  initial begin
    int   dcount;
    int   l1;
    int   l32;
    int   edges;
    exp_t pe;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; sub = 1'b0; cin = 1'b0;
    src1 = '0; src2 = '0; last_sum = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_sum",  sum_m,  64'd0);
    check_val("rst_cout", cout_m, 64'd0);
    check_val("rst_ovf",  ovf_m,  64'd0);
    check_val("rst_zero", zero_m, 64'd0);
    check_val("rst_busy", busy_m, 64'd0);
    check_val("rst_done", done_m, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    va[0] = 32'hFFFF_FFFF; vb[0] = 32'h0000_0001; vs[0] = 1'b0; vc[0] = 1'b0;
    va[1] = 32'h7FFF_FFFF; vb[1] = 32'h0000_0001; vs[1] = 1'b0; vc[1] = 1'b0;
    va[2] = 32'h0000_0003; vb[2] = 32'h0000_0004; vs[2] = 1'b0; vc[2] = 1'b1;
    va[3] = 32'h0000_0005; vb[3] = 32'h0000_0007; vs[3] = 1'b1; vc[3] = 1'b0;
    va[4] = 32'h8000_0000; vb[4] = 32'h0000_0001; vs[4] = 1'b1; vc[4] = 1'b0;
    va[5] = 32'h0000_000A; vb[5] = 32'h0000_0003; vs[5] = 1'b1; vc[5] = 1'b1;
    va[6] = 32'h1234_5678; vb[6] = 32'h1234_5678; vs[6] = 1'b1; vc[6] = 1'b0;
    va[7] = 32'h8000_0000; vb[7] = 32'h8000_0000; vs[7] = 1'b0; vc[7] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      launch(va[i], vb[i], vs[i], vc[i], 1'b1);
      wait_done($sformatf("dir%0d", i), 1'b0);
    end

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      launch($urandom, $urandom, 1'(i % 2), 1'($urandom_range(0, 1)), 1'b1);
      wait_done($sformatf("rnd%0d", i), 1'b0);
    end

    @(negedge clk);
    launch(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1);
    wait_done("disturb", 1'b1);

    @(negedge clk);
    launch(32'hDEAD_BEEF, 32'h0000_1111, 1'b0, 1'b1, 1'b1);
    wait_done("b2b_first", 1'b0);
    launch(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 1'b1);
    wait_done("b2b_second", 1'b0);

    repeat (3) @(negedge clk);
    check_val("hold_idle", sum_m, last_sum);

    @(negedge clk);
    launch(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_val("hold_run", sum_m, last_sum);
    check_val("busy_run", busy_m, 64'd1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_sum",  sum_m,  64'd0);
    check_val("mid_rst_cout", cout_m, 64'd0);
    check_val("mid_rst_ovf",  ovf_m,  64'd0);
    check_val("mid_rst_zero", zero_m, 64'd0);
    check_val("mid_rst_busy", busy_m, 64'd0);
    check_val("mid_rst_done", done_m, 64'd0);
    last_sum = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (15) begin
      @(negedge clk);
      if (done_m) dcount++;
    end
    check_val("no_done_after_rst", dcount, 64'd0);

    @(negedge clk);
    launch(32'd1, 32'd1, 1'b0, 1'b0, 1'b1);
    wait_done("after_rst", 1'b0);

    // Let the DIGIT=1 instance finish before probing latency on all widths.
    repeat (40) @(negedge clk);
    launch(32'h89AB_CDEF, 32'h1234_5678, 1'b0, 1'b1, 1'b1);
    pe = model(32'h89AB_CDEF, 32'h1234_5678, 1'b0, 1'b1);
    @(posedge clk);
    #1 start = 1'b0;
    edges = 0; l1 = -1; l32 = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done_1 && l1 < 0) begin
        l1 = edges;
        check_val("d1_sum",  sum_1,  pe.sum);
        check_val("d1_cout", cout_1, pe.cout);
      end
      if (done_32 && l32 < 0) begin
        l32 = edges;
        check_val("d32_sum", sum_32, pe.sum);
        check_val("d32_ovf", ovf_32, pe.ovf);
      end
      if (l1 >= 0 && l32 >= 0) break;
      @(posedge clk);
      edges++;
    end
    check_val("d1_latency",  l1,  64'd32);
    check_val("d32_latency", l32, 64'd1);

`ifdef MULTI_CYCLE_ADDER_ABORT_EN
    repeat (5) @(negedge clk);
    launch(32'h5555_5555, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check_val("abort_busy_m", busy_m, 64'd0);
    check_val("abort_busy_d1", busy_1, 64'd0);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_m || done_1) dcount++;
    end
    check_val("abort_no_done", dcount, 64'd0);
    check_val("abort_keep_sum", sum_m, last_sum);
    @(negedge clk);
    launch(32'h0000_0100, 32'h0000_0023, 1'b1, 1'b0, 1'b1);
    wait_done("post_abort", 1'b0);
`endif

    repeat (4) @(negedge clk);
    check_val("sb_empty", sb_q.size(), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
